// File: rtl/udp_pkg.sv
// udp_pkg: shared constants and types for the UDP receive stage.
// Header field offsets on beat 0, user-field layout and FSM state encoding.
package udp_pkg;

    // UDP header size in bytes
    localparam int unsigned UDP_HDR_BYTES = 8;

    // Field widths
    localparam int unsigned PORT_W = 16;
    localparam int unsigned LEN_W  = 16;

    // Beat-0 header field offsets (LSB positions within the 64-bit word)
    localparam int unsigned HDR_SRC_LSB = 48;
    localparam int unsigned HDR_DST_LSB = 32;
    localparam int unsigned HDR_LEN_LSB = 16;

    // Input user field: IP payload byte length position
    localparam int unsigned IP_LEN_LSB = 40;

    // Receive FSM states
    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        PASS,
        DROP
    } state_t;

endpackage

// File: rtl/udp_port_table.sv
// udp_port_table: runtime-programmable listen-port table.
// Register file of port/enable pairs with a parallel compare; reports a hit
// and the lowest matching index combinationally from the looked-up port.
module udp_port_table
    import udp_pkg::*;
#(
    parameter int unsigned P_PORT_NUM  = 4,
    parameter logic [15:0] P_BASE_PORT = 16'h0808,
    parameter int unsigned P_IDX_W     = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               wr_en_i,
    input  logic [P_IDX_W-1:0] wr_idx_i,
    input  logic [PORT_W-1:0]  wr_port_i,
    input  logic               wr_ena_i,
    input  logic [PORT_W-1:0]  lookup_port_i,
    output logic               hit_o,
    output logic [P_IDX_W-1:0] idx_o
);

    logic [PORT_W-1:0]     port_q [P_PORT_NUM];
    logic [P_PORT_NUM-1:0] en_q;

    // Table storage; an index with no matching entry is silently ignored
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < P_PORT_NUM; k++) begin
                port_q[k] <= P_BASE_PORT + PORT_W'(k);
            end
            en_q <= '1;
        end else if (wr_en_i) begin
            for (int unsigned k = 0; k < P_PORT_NUM; k++) begin
                if (wr_idx_i == P_IDX_W'(k)) begin
                    port_q[k] <= wr_port_i;
                    en_q[k]   <= wr_ena_i;
                end
            end
        end
    end

    // Parallel compare with lowest-index priority
    always_comb begin
        logic found;
        found = 1'b0;
        idx_o = '0;
        for (int unsigned k = 0; k < P_PORT_NUM; k++) begin
            if (!found && en_q[k] && (port_q[k] == lookup_port_i)) begin
                found = 1'b1;
                idx_o = P_IDX_W'(k);
            end
        end
        hit_o = found;
    end

endmodule

// File: rtl/udp_rx_mport.sv
// udp_rx_mport: UDP receive stage with a multi-entry listen-port table.
// Parses the header on beat 0, forwards matching payloads with metadata
// {src_port, idx, payload_bytes}, drops everything else.
// Optional build macro UDP_RX_STATS_EN adds saturating ok/drop counters.
module udp_rx_mport
    import udp_pkg::*;
#(
    parameter int unsigned P_PORT_NUM  = 4,
    parameter logic [15:0] P_BASE_PORT = 16'h0808,
    parameter int unsigned P_IDX_W     = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_port_wr_en,
    input  logic [P_IDX_W-1:0]      i_port_wr_idx,
    input  logic [15:0]             i_port_wr_port,
    input  logic                    i_port_wr_ena,
    input  logic [63:0]             s_axis_ip_data,
    input  logic [55:0]             s_axis_ip_user,
    input  logic [7:0]              s_axis_ip_keep,
    input  logic                    s_axis_ip_last,
    input  logic                    s_axis_ip_valid,
    output logic [63:0]             m_axis_user_data,
    output logic [32+P_IDX_W-1:0]   m_axis_user_user,
    output logic [7:0]              m_axis_user_keep,
    output logic                    m_axis_user_last,
    output logic                    m_axis_user_valid
`ifdef UDP_RX_STATS_EN
    ,
    output logic [31:0]             o_pkt_ok_cnt,
    output logic [31:0]             o_pkt_drop_cnt
`endif
);

    localparam int unsigned UW = 32 + P_IDX_W;

    logic [PORT_W-1:0]  hdr_src;
    logic [PORT_W-1:0]  hdr_dst;
    logic [LEN_W-1:0]   hdr_len;
    logic [LEN_W-1:0]   ip_len;
    logic               tbl_hit;
    logic [P_IDX_W-1:0] tbl_idx;
    logic               hdr_ok;
    logic               unused_user;

    state_t             state_q;
    logic [UW-1:0]      meta_q;
    logic               s1_valid_q;
    logic               s1_last_q;
    logic [63:0]        s1_data_q;
    logic [7:0]         s1_keep_q;
    logic [UW-1:0]      s1_user_q;

    assign hdr_src     = s_axis_ip_data[HDR_SRC_LSB +: PORT_W];
    assign hdr_dst     = s_axis_ip_data[HDR_DST_LSB +: PORT_W];
    assign hdr_len     = s_axis_ip_data[HDR_LEN_LSB +: LEN_W];
    assign ip_len      = s_axis_ip_user[IP_LEN_LSB +: LEN_W];
    assign unused_user = ^s_axis_ip_user[IP_LEN_LSB-1:0];

    // The table is looked up on the raw input so a same-cycle write is not seen
    udp_port_table #(
        .P_PORT_NUM  (P_PORT_NUM),
        .P_BASE_PORT (P_BASE_PORT),
        .P_IDX_W     (P_IDX_W)
    ) u_port_table (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .wr_en_i       (i_port_wr_en),
        .wr_idx_i      (i_port_wr_idx),
        .wr_port_i     (i_port_wr_port),
        .wr_ena_i      (i_port_wr_ena),
        .lookup_port_i (hdr_dst),
        .hit_o         (tbl_hit),
        .idx_o         (tbl_idx)
    );

    // Header acceptance rule; a header carrying last is never accepted
    always_comb begin
        hdr_ok = tbl_hit && (hdr_len == ip_len) &&
                 (hdr_len > LEN_W'(UDP_HDR_BYTES)) && !s_axis_ip_last;
    end

    // Packet FSM driving the input register stage; SYNC runs on the raw input
    // so a frame still streaming when reset releases is caught on its first beat
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= SYNC;
            meta_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_keep_q  <= '1;
            s1_user_q  <= '0;
        end else begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            unique case (state_q)
                SYNC: begin
                    state_q <= s_axis_ip_valid ? DROP : IDLE;
                end
                IDLE: begin
                    if (s_axis_ip_valid) begin
                        if (hdr_ok) begin
                            state_q <= PASS;
                            meta_q  <= {hdr_src, tbl_idx,
                                        hdr_len - LEN_W'(UDP_HDR_BYTES)};
                        end else if (!s_axis_ip_last) begin
                            state_q <= DROP;
                        end
                    end
                end
                PASS: begin
                    if (s_axis_ip_valid) begin
                        s1_valid_q <= 1'b1;
                        s1_last_q  <= s_axis_ip_last;
                        s1_data_q  <= s_axis_ip_data;
                        s1_keep_q  <= s_axis_ip_last ? s_axis_ip_keep : 8'hff;
                        s1_user_q  <= meta_q;
                        if (s_axis_ip_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (s_axis_ip_valid && s_axis_ip_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    // Output register stage; payload fields hold during gaps
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_axis_user_valid <= 1'b0;
            m_axis_user_last  <= 1'b0;
            m_axis_user_data  <= '0;
            m_axis_user_keep  <= '1;
            m_axis_user_user  <= '0;
        end else begin
            m_axis_user_valid <= s1_valid_q;
            m_axis_user_last  <= s1_last_q;
            if (s1_valid_q) begin
                m_axis_user_data <= s1_data_q;
                m_axis_user_keep <= s1_keep_q;
                m_axis_user_user <= s1_user_q;
            end
        end
    end

`ifdef UDP_RX_STATS_EN
    logic [31:0] ok_cnt_q;
    logic [31:0] ok_cnt_d;
    logic [31:0] drop_cnt_q;
    logic [31:0] drop_cnt_d;

    // Saturating counter next-state; IDLE rejections include header-only frames
    always_comb begin
        ok_cnt_d   = ok_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if ((state_q == PASS) && s_axis_ip_valid && s_axis_ip_last &&
            (ok_cnt_q != '1)) begin
            ok_cnt_d = ok_cnt_q + 32'd1;
        end
        if ((state_q == IDLE) && s_axis_ip_valid && !hdr_ok &&
            (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            ok_cnt_q   <= ok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_pkt_ok_cnt   = ok_cnt_q;
    assign o_pkt_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_udp_rx_mport.sv
// tb_udp_rx_mport: self-checking bench for udp_rx_mport.
// Packet-level reference model (table lookup + accept rule) feeds an expected
// beat queue; a monitor collects output beats for comparison.
module tb_udp_rx_mport;

    localparam int NP = 4;
    localparam int IW = 2;
    localparam int UW = 32 + IW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_port_wr_en;
    logic [IW-1:0] i_port_wr_idx;
    logic [15:0]   i_port_wr_port;
    logic          i_port_wr_ena;
    logic [63:0]   s_axis_ip_data;
    logic [55:0]   s_axis_ip_user;
    logic [7:0]    s_axis_ip_keep;
    logic          s_axis_ip_last;
    logic          s_axis_ip_valid;
    logic [63:0]   m_axis_user_data;
    logic [UW-1:0] m_axis_user_user;
    logic [7:0]    m_axis_user_keep;
    logic          m_axis_user_last;
    logic          m_axis_user_valid;
`ifdef UDP_RX_STATS_EN
    logic [31:0]   ok_cnt;
    logic [31:0]   drop_cnt;
`endif

    udp_rx_mport #(
        .P_PORT_NUM  (NP),
        .P_BASE_PORT (16'h0808),
        .P_IDX_W     (IW)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_port_wr_en      (i_port_wr_en),
        .i_port_wr_idx     (i_port_wr_idx),
        .i_port_wr_port    (i_port_wr_port),
        .i_port_wr_ena     (i_port_wr_ena),
        .s_axis_ip_data    (s_axis_ip_data),
        .s_axis_ip_user    (s_axis_ip_user),
        .s_axis_ip_keep    (s_axis_ip_keep),
        .s_axis_ip_last    (s_axis_ip_last),
        .s_axis_ip_valid   (s_axis_ip_valid),
        .m_axis_user_data  (m_axis_user_data),
        .m_axis_user_user  (m_axis_user_user),
        .m_axis_user_keep  (m_axis_user_keep),
        .m_axis_user_last  (m_axis_user_last),
        .m_axis_user_valid (m_axis_user_valid)
`ifdef UDP_RX_STATS_EN
        ,
        .o_pkt_ok_cnt      (ok_cnt),
        .o_pkt_drop_cnt    (drop_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0]   data;
        logic [UW-1:0] user;
        logic [7:0]    keep;
        logic          last;
        int            cyc;
    } beat_t;

    typedef struct {
        logic [15:0] dst;
        logic [15:0] ulen;
        logic [15:0] iplen;
        int          npay;
        logic [7:0]  lkeep;
        bit          gaps;
        bit          chain;
        int          exp_beats;
    } vec_t;

    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic [15:0] mdl_port[NP];
    bit          mdl_en[NP];
    int          exp_ok;
    int          exp_drop;
    int          pay_cyc;

    // Output monitor
    always @(negedge i_clk) begin : mon
        beat_t b;
        if (!i_rst && m_axis_user_valid) begin
            b.data = m_axis_user_data;
            b.user = m_axis_user_user;
            b.keep = m_axis_user_keep;
            b.last = m_axis_user_last;
            b.cyc  = cyc;
            got_q.push_back(b);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < NP; k++) begin
            mdl_port[k] = 16'h0808 + 16'(k);
            mdl_en[k]   = 1'b1;
        end
        exp_ok   = 0;
        exp_drop = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    function automatic int lookup(input logic [15:0] dst);
        for (int k = 0; k < NP; k++) begin
            if (mdl_en[k] && mdl_port[k] == dst) return k;
        end
        return -1;
    endfunction

    function automatic logic [15:0] pick_port();
        case ($urandom_range(0, 5))
            0: return 16'h0808;
            1: return 16'h0809;
            2: return 16'h080A;
            3: return 16'h080B;
            4: return 16'h1234;
            default: return 16'h4321;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            s_axis_ip_valid = 1'b0;
            s_axis_ip_last  = 1'($urandom_range(0, 1));
            s_axis_ip_data  = {$urandom, $urandom};
            i_port_wr_en    = 1'b0;
        end
    endtask

    task automatic write_port(input logic [IW-1:0] idx, input logic [15:0] port, input bit ena);
        @(negedge i_clk);
        s_axis_ip_valid = 1'b0;
        i_port_wr_en    = 1'b1;
        i_port_wr_idx   = idx;
        i_port_wr_port  = port;
        i_port_wr_ena   = ena;
        mdl_port[idx]   = port;
        mdl_en[idx]     = ena;
    endtask

    // Drives one frame; ends right after the last beat so calls can be chained
    task automatic send_pkt(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] ulen, input logic [15:0] iplen,
                            input int npay, input logic [7:0] lkeep, input bit gaps,
                            input bit hw, input logic [IW-1:0] widx,
                            input logic [15:0] wport, input bit wena);
        int    idx;
        bit    pass;
        beat_t e;
        idx  = lookup(dst);
        pass = (idx >= 0) && (ulen == iplen) && (ulen > 16'd8) && (npay > 0);
        if (pass) exp_ok++;
        else exp_drop++;
        @(negedge i_clk);
        s_axis_ip_valid = 1'b1;
        s_axis_ip_data  = {src, dst, ulen, 16'($urandom)};
        s_axis_ip_user  = {iplen, 32'($urandom), 8'($urandom)};
        s_axis_ip_keep  = 8'($urandom);
        s_axis_ip_last  = (npay == 0);
        i_port_wr_en    = hw;
        i_port_wr_idx   = widx;
        i_port_wr_port  = wport;
        i_port_wr_ena   = wena;
        if (hw) begin
            mdl_port[widx] = wport;
            mdl_en[widx]   = wena;
        end
        for (int b = 0; b < npay; b++) begin
            if (gaps) idle($urandom_range(0, 2));
            @(negedge i_clk);
            i_port_wr_en    = 1'b0;
            s_axis_ip_valid = 1'b1;
            s_axis_ip_data  = {$urandom, $urandom};
            s_axis_ip_last  = (b == npay - 1);
            s_axis_ip_keep  = s_axis_ip_last ? lkeep : 8'($urandom);
            if (b == 0) pay_cyc = cyc;
            if (pass) begin
                e.data = s_axis_ip_data;
                e.user = {src, IW'(idx), ulen - 16'd8};
                e.keep = s_axis_ip_last ? lkeep : 8'hff;
                e.last = s_axis_ip_last;
                e.cyc  = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef UDP_RX_STATS_EN
        chk({name, " ok_cnt"}, ok_cnt, exp_ok);
        chk({name, " drop_cnt"}, drop_cnt, exp_drop);
`endif
    endtask

    task automatic check_pkts(input string name, output int n);
        int m;
        idle(4);
        n = got_q.size();
        chk({name, " beat count"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s beat%0d", name, i),
                {got_q[i].data, got_q[i].user, got_q[i].keep, got_q[i].last},
                {exp_q[i].data, exp_q[i].user, exp_q[i].keep, exp_q[i].last});
        end
        chk_stats(name);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_first_idx(input string name, input int exp_idx);
        logic [IW-1:0] gi;
        idle(4);
        gi = (got_q.size() > 0) ? got_q[0].user[16 +: IW] : 'x;
        chk(name, gi, exp_idx);
    endtask

    vec_t vecs[9];
    int   n;
    int   acc;

    initial begin
        vecs[0] = '{16'h080A, 16'd24, 16'd24, 2, 8'h0f, 1'b0, 1'b0, 2};
        vecs[1] = '{16'h080B, 16'd17, 16'd17, 2, 8'h01, 1'b0, 1'b0, 2};
        vecs[2] = '{16'h0900, 16'd24, 16'd24, 2, 8'hff, 1'b0, 1'b0, 0};
        vecs[3] = '{16'h0808, 16'd24, 16'd32, 2, 8'hff, 1'b0, 1'b1, 0};
        vecs[4] = '{16'h0808, 16'd24, 16'd24, 3, 8'h3f, 1'b0, 1'b0, 3};
        vecs[5] = '{16'h0809, 16'd8,  16'd8,  0, 8'hff, 1'b0, 1'b0, 0};
        vecs[6] = '{16'h0809, 16'd8,  16'd8,  1, 8'hff, 1'b0, 1'b0, 0};
        vecs[7] = '{16'h0808, 16'd9,  16'd9,  1, 8'h01, 1'b0, 1'b0, 1};
        vecs[8] = '{16'h080A, 16'd40, 16'd40, 4, 8'h80, 1'b1, 1'b0, 4};

        i_rst = 1'b1;
        i_port_wr_en = 1'b0; i_port_wr_idx = '0; i_port_wr_port = '0; i_port_wr_ena = 1'b0;
        s_axis_ip_data = '0; s_axis_ip_user = '0; s_axis_ip_keep = '0;
        s_axis_ip_last = 1'b0; s_axis_ip_valid = 1'b0;
        mdl_reset();
        repeat (3) @(negedge i_clk);
        chk("reset outputs",
            {m_axis_user_valid, m_axis_user_last, m_axis_user_keep, m_axis_user_data, m_axis_user_user},
            {1'b0, 1'b0, 8'hff, 64'h0, {UW{1'b0}}});
        chk_stats("reset");
        i_rst = 1'b0;
        idle(2);

        // Basic 3-beat packet with latency check
        send_pkt(16'hABCD, 16'h0809, 16'd24, 16'd24, 2, 8'hf0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(4);
        chk("t1 beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t1 latency", got_q[0].cyc - pay_cyc, 2);
            chk("t1 user", got_q[0].user, {16'hABCD, 2'd1, 16'd16});
            chk("t1 beat0 keep/last", {got_q[0].keep, got_q[0].last}, {8'hff, 1'b0});
            chk("t1 beat1 keep/last", {got_q[1].keep, got_q[1].last}, {8'hf0, 1'b1});
        end
        check_pkts("t1", n);

        // Table-driven vectors against the reset table
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            send_pkt(16'h1000 + 16'(i), vecs[i].dst, vecs[i].ulen, vecs[i].iplen, vecs[i].npay,
                     vecs[i].lkeep, vecs[i].gaps, 1'b0, '0, '0, 1'b0);
            acc += vecs[i].exp_beats;
            if (!vecs[i].chain) begin
                check_pkts($sformatf("vec%0d", i), n);
                chk($sformatf("vec%0d table beats", i), n, acc);
                acc = 0;
            end
        end

        // Reset asserted while beat 2 of a 5-beat frame is on the wire
        @(negedge i_clk);
        s_axis_ip_valid = 1'b1; s_axis_ip_last = 1'b0;
        s_axis_ip_data  = {16'h1111, 16'h0809, 16'd40, 16'h0};
        s_axis_ip_user  = {16'd40, 40'h0};
        @(negedge i_clk); s_axis_ip_data = {$urandom, $urandom};
        @(negedge i_clk); s_axis_ip_data = {$urandom, $urandom};
        @(posedge i_clk); #1;
        chk("rst pre valid", m_axis_user_valid, 1'b1);
        i_rst = 1'b1;
        #1;
        chk("rst outputs cleared",
            {m_axis_user_valid, m_axis_user_last, m_axis_user_keep, m_axis_user_data, m_axis_user_user},
            {1'b0, 1'b0, 8'hff, 64'h0, {UW{1'b0}}});
        @(negedge i_clk); s_axis_ip_data = {$urandom, $urandom};
        #2 i_rst = 1'b0;
        @(negedge i_clk); s_axis_ip_data = {$urandom, $urandom}; s_axis_ip_last = 1'b1;
        mdl_reset();
        check_pkts("rst tail", n);
        send_pkt(16'h2222, 16'h0808, 16'd20, 16'd20, 2, 8'h07, 1'b0, 1'b0, '0, '0, 1'b0);
        check_pkts("rst next", n);

        // Disabled entry, then re-enabled
        write_port(2'd2, 16'h1234, 1'b0);
        send_pkt(16'h3333, 16'h1234, 16'd24, 16'd24, 2, 8'hff, 1'b0, 1'b0, '0, '0, 1'b0);
        check_pkts("dis", n);
        write_port(2'd2, 16'h1234, 1'b1);
        send_pkt(16'h3334, 16'h1234, 16'd24, 16'd24, 2, 8'hff, 1'b0, 1'b0, '0, '0, 1'b0);
        chk_first_idx("reen idx", 2);
        check_pkts("reen", n);

        // Duplicate entries: lowest index wins
        write_port(2'd3, 16'h0808, 1'b1);
        send_pkt(16'h4444, 16'h0808, 16'd16, 16'd16, 1, 8'hff, 1'b0, 1'b0, '0, '0, 1'b0);
        chk_first_idx("dup idx", 0);
        check_pkts("dup", n);

        // Write coinciding with a header that only the new value would match
        write_port(2'd0, 16'hAAAA, 1'b1);
        write_port(2'd3, 16'hBBBB, 1'b1);
        send_pkt(16'h5555, 16'h0808, 16'd16, 16'd16, 1, 8'hff, 1'b0, 1'b1, 2'd1, 16'h0808, 1'b1);
        check_pkts("samecyc", n);
        send_pkt(16'h5556, 16'h0808, 16'd16, 16'd16, 1, 8'hff, 1'b0, 1'b0, '0, '0, 1'b0);
        chk_first_idx("samecyc next idx", 1);
        check_pkts("samecyc next", n);

        // Randomized traffic against the reference model
        for (int it = 0; it < 80; it++) begin
            logic [15:0] ulen;
            logic [15:0] iplen;
            int          r;
            if ($urandom_range(0, 3) == 0)
                write_port(IW'($urandom_range(0, NP - 1)), pick_port(), $urandom_range(0, 4) != 0);
            r     = $urandom_range(0, 9);
            ulen  = 16'($urandom_range(9, 64));
            iplen = ulen;
            if (r == 0) begin ulen = 16'd8; iplen = 16'd8; end
            if (r == 1) iplen = ulen + 16'd1;
            send_pkt(16'($urandom), pick_port(), ulen, iplen, $urandom_range(0, 4),
                     8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7) == 0, IW'($urandom_range(0, NP - 1)),
                     pick_port(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) check_pkts($sformatf("rand%0d", it), n);
        end
        check_pkts("rand final", n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_rx_mport.md
Name: udp_rx_mport

Overview:
- Parametrised successor of the single-port UDP receive stage.
- Sits between the IP RX layer and user logic on the 64-bit AXIS-style datapath, which has no backpressure.
- Parses the 8-byte UDP header on beat 0 and checks the destination port against a runtime-programmable table of P_PORT_NUM listen ports.
- On a match, forwards the payload with metadata (source port, matched index, byte length). Everything else is dropped.

Parameters:
- P_PORT_NUM, 4, number of listen-port table entries (1..16).
- P_BASE_PORT, 16'h0808, reset value of entry k is P_BASE_PORT+k.
- P_IDX_W, 2, width of the matched-index field; must equal clog2(P_PORT_NUM), minimum 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_port_wr_en  in  1  table write strobe
- i_port_wr_idx  in  P_IDX_W  table entry to write
- i_port_wr_port  in  16  port value to write
- i_port_wr_ena  in  1  entry enable bit to write
- s_axis_ip_data  in  64  beat 0: [63:48] src port, [47:32] dst port, [31:16] UDP len, [15:0] checksum; later beats are payload
- s_axis_ip_user  in  56  [55:40] IP payload byte length (UDP header included)
- s_axis_ip_keep  in  8  byte enables, meaningful on the last beat only
- s_axis_ip_last  in  1  end of packet
- s_axis_ip_valid  in  1  beat valid
- m_axis_user_data  out  64  payload
- m_axis_user_user  out  32+P_IDX_W  {src_port[15:0], idx, payload_bytes[15:0]}
- m_axis_user_keep  out  8  byte enables
- m_axis_user_last  out  1  end of payload
- m_axis_user_valid  out  1  beat valid

Behaviour:
- Reset values:
  - All outputs 0, except m_axis_user_keep = 8'hff.
  - Table entry k = P_BASE_PORT+k, enabled.
  - FSM in SYNC.
- Pipeline: input register stage, then output register. A payload beat accepted at cycle t appears at t+2.
- FSM states:
  - SYNC (after reset): if the first post-reset cycle has valid=1, go to DROP; otherwise go to IDLE. This discards any frame caught mid-flight by reset.
  - IDLE: the first valid beat is the header. Go to PASS only if all of the following hold:
    - dst port equals an enabled table entry;
    - UDP len == user[55:40];
    - UDP len > 8;
    - last = 0.
    Otherwise go to DROP. If last = 1 on the header beat, stay in IDLE.
  - PASS: forward each valid beat. On a valid beat with last = 1, go to IDLE.
  - DROP: discard beats. On a valid beat with last = 1, go to IDLE.
- Multiple table hits: the lowest index wins.
- Header beat is never forwarded.
- Gaps in valid within a packet are allowed: state holds, and output valid is 0 for the gap cycles.
- Metadata:
  - user is latched at the header and held constant for the whole packet.
  - payload_bytes = UDP len - 8 (16-bit; UDP len ≥ 9 guaranteed by the accept rule).
- keep:
  - Non-last output beats: 8'hff.
  - Last output beat: input keep, passed through unchanged.
- Table write:
  - A write at cycle t takes effect at t+1. A header in the same cycle is compared against the old contents.
  - Writes with idx ≥ P_PORT_NUM are ignored.
  - Writing an entry mid-packet does not affect the packet in flight.
- Asynchronous reset mid-packet: outputs go to reset values immediately, with no partial last. Remaining beats of that frame are dropped through SYNC.

Optional Feature:
- Macro UDP_RX_STATS_EN.
- Defined:
  - Adds outputs o_pkt_ok_cnt[31:0] and o_pkt_drop_cnt[31:0], saturating at 32'hFFFF_FFFF, reset to 0.
  - ok increments when a PASS packet's last beat is accepted.
  - drop increments at the decision to enter DROP, or when IDLE rejects a header-only packet.
  - SYNC discards are not counted.
- Undefined: the ports and logic do not exist; behaviour is otherwise identical.

Decomposition:
- Package udp_pkg:
  - Header field offsets.
  - UDP_HDR_BYTES = 8.
  - FSM state enum (SYNC, IDLE, PASS, DROP).
  - User-field layout widths.
- Sub-module udp_port_table: register file plus parallel compare. Outputs hit and lowest matching index combinationally from the dst port.

Test Plan:
- Reset, then a 3-beat packet: dst 16'h0809, UDP len 24, user len 24, last keep 8'hf0. Output: 2 beats, user = {src, idx 1, 16}, second beat last with keep 8'hf0, first output beat 2 cycles after input beat 1.
- Write entry 2 = 16'h1234 with enable 0, then send to 16'h1234 → dropped, no output valid. Re-enable entry 2 → next packet passes with idx 2.
- UDP len 24 but user len 32 → dropped. A following valid packet back-to-back passes intact.
- Header-only packet (UDP len 8, last on beat 0) → no output. With UDP_RX_STATS_EN, drop count = 1.
- Assert i_rst during beat 2 of a 5-beat packet, with valid still high after release → outputs cleared, remaining beats discarded, next packet passes. With UDP_RX_STATS_EN, counters read 0 then ok = 1.
- Table entries 0 and 3 both set to 16'h0808 → a matching packet reports idx 0. A table write to 16'h0808 in the same cycle as a header matching only the new value → that packet is dropped.
